// File: rtl/ccip_mmio_responder.sv
// CCI-P MMIO responder: AFU DFH/ID header plus two RW scratch registers; optional counters via CCIP_MMIO_RESPONDER_STATS_EN.
// Latency: a read sampled in cycle N responds in cycle N+2; writes take effect in cycle N+2.
// Backpressure: none; one request per cycle is always accepted and every read gets exactly one response.
module ccip_mmio_responder #(
    parameter logic [63:0] DFH_VALUE = 64'h1000_0000_0000_1000,
    parameter logic [63:0] AFU_ID_L  = 64'h0,
    parameter logic [63:0] AFU_ID_H  = 64'h0
) (
    input  logic        pClk,
    input  logic        pck_cp2af_softReset_n,
    input  logic        mmio_wr_valid,
    input  logic        mmio_rd_valid,
    input  logic [15:0] mmio_addr,
    input  logic [1:0]  mmio_len,
    input  logic [8:0]  mmio_tid,
    input  logic [63:0] mmio_wdata,
    output logic        rsp_valid,
    output logic [8:0]  rsp_tid,
    output logic [63:0] rsp_data
);

    // Register indices are the DWORD address with bit 0 dropped (one per 64-bit register).
    localparam logic [14:0] REG_DFH   = 15'd0;
    localparam logic [14:0] REG_AFU_L = 15'd1;
    localparam logic [14:0] REG_AFU_H = 15'd2;
    localparam logic [14:0] REG_SCR0  = 15'd8;
    localparam logic [14:0] REG_SCR1  = 15'd9;
`ifdef CCIP_MMIO_RESPONDER_STATS_EN
    localparam logic [14:0] REG_RDCNT = 15'd10;
    localparam logic [14:0] REG_WRCNT = 15'd11;
`endif

    logic        s1_rd;
    logic        s1_wr;
    logic [15:0] s1_addr;
    logic [1:0]  s1_len;
    logic [8:0]  s1_tid;
    logic [63:0] s1_wdata;

    logic [63:0] scratch0;
    logic [63:0] scratch1;

    logic [14:0] s1_idx;
    logic        s1_dw;
    logic        s1_hi;
    logic [63:0] reg_val;
    logic [63:0] rd_val;

    assign s1_idx = s1_addr[15:1];
    assign s1_dw  = (s1_len == 2'd0);
    assign s1_hi  = s1_addr[0];

    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            s1_rd    <= 1'b0;
            s1_wr    <= 1'b0;
            s1_addr  <= 16'h0;
            s1_len   <= 2'd0;
            s1_tid   <= 9'h0;
            s1_wdata <= 64'h0;
        end else begin
            s1_rd    <= mmio_rd_valid;
            s1_wr    <= mmio_wr_valid;
            s1_addr  <= mmio_addr;
            s1_len   <= mmio_len;
            s1_tid   <= mmio_tid;
            s1_wdata <= mmio_wdata;
        end
    end

`ifdef CCIP_MMIO_RESPONDER_STATS_EN
    logic [31:0] rd_count;
    logic [31:0] wr_count;
    logic        clr_rd;
    logic        clr_wr;

    assign clr_rd = s1_wr && (s1_idx == REG_RDCNT);
    assign clr_wr = s1_wr && (s1_idx == REG_WRCNT);

    // A clearing write and a read in the same cycle: the read is still counted.
    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            rd_count <= 32'h0;
            wr_count <= 32'h0;
        end else begin
            rd_count <= (clr_rd ? 32'h0 : rd_count) + {31'h0, s1_rd};
            if (clr_wr) begin
                wr_count <= 32'h0;
            end else if (s1_wr && !clr_rd) begin
                wr_count <= wr_count + 32'h1;
            end
        end
    end
`endif

    always_comb begin
        reg_val = 64'h0;
        case (s1_idx)
            REG_DFH:   reg_val = DFH_VALUE;
            REG_AFU_L: reg_val = AFU_ID_L;
            REG_AFU_H: reg_val = AFU_ID_H;
            REG_SCR0:  reg_val = scratch0;
            REG_SCR1:  reg_val = scratch1;
`ifdef CCIP_MMIO_RESPONDER_STATS_EN
            REG_RDCNT: reg_val = {32'h0, rd_count};
            REG_WRCNT: reg_val = {32'h0, wr_count};
`endif
            default:   reg_val = 64'h0;
        endcase
    end

    assign rd_val = s1_dw ? {32'h0, (s1_hi ? reg_val[63:32] : reg_val[31:0])} : reg_val;

    function automatic logic [63:0] wr_merge(input logic [63:0] old, input logic [63:0] wdata,
                                             input logic dw, input logic hi);
        if (!dw)
            return wdata;
        else if (hi)
            return {wdata[31:0], old[31:0]};
        else
            return {old[63:32], wdata[31:0]};
    endfunction

    // Scratch updates land on the same edge that registers a same-cycle read, so that read sees the old value.
    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            scratch0 <= 64'h0;
            scratch1 <= 64'h0;
        end else if (s1_wr) begin
            if (s1_idx == REG_SCR0)
                scratch0 <= wr_merge(scratch0, s1_wdata, s1_dw, s1_hi);
            if (s1_idx == REG_SCR1)
                scratch1 <= wr_merge(scratch1, s1_wdata, s1_dw, s1_hi);
        end
    end

    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            rsp_valid <= 1'b0;
            rsp_tid   <= 9'h0;
            rsp_data  <= 64'h0;
        end else begin
            rsp_valid <= s1_rd;
            if (s1_rd) begin
                rsp_tid  <= s1_tid;
                rsp_data <= rd_val;
            end
        end
    end

endmodule

// File: tb/tb_ccip_mmio_responder.sv
// Bench for ccip_mmio_responder: register-map model with per-cycle response checking plus literal scenario checks.
module tb_ccip_mmio_responder;

    localparam logic [63:0] P_DFH  = 64'h1000_0000_0000_1000;
    localparam logic [63:0] P_AFUL = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] P_AFUH = 64'hFEDC_BA98_7654_3210;
`ifdef CCIP_MMIO_RESPONDER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        pClk;
    logic        rst_n;
    logic        wr_valid;
    logic        rd_valid;
    logic [15:0] addr;
    logic [1:0]  len;
    logic [8:0]  tid;
    logic [63:0] wdata;
    logic        rsp_valid;
    logic [8:0]  rsp_tid;
    logic [63:0] rsp_data;

    ccip_mmio_responder #(
        .DFH_VALUE(P_DFH),
        .AFU_ID_L (P_AFUL),
        .AFU_ID_H (P_AFUH)
    ) dut (
        .pClk                 (pClk),
        .pck_cp2af_softReset_n(rst_n),
        .mmio_wr_valid        (wr_valid),
        .mmio_rd_valid        (rd_valid),
        .mmio_addr            (addr),
        .mmio_len             (len),
        .mmio_tid             (tid),
        .mmio_wdata           (wdata),
        .rsp_valid            (rsp_valid),
        .rsp_tid              (rsp_tid),
        .rsp_data             (rsp_data)
    );

    initial pClk = 1'b0;
    always #5 pClk = ~pClk;

    typedef struct {
        logic [8:0]  tid;
        logic [63:0] data;
        int          cyc;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t obs_q[$];
    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    logic [63:0] m_scr0 = 64'h0;
    logic [63:0] m_scr1 = 64'h0;
    logic [31:0] m_rdc = 32'h0;
    logic [31:0] m_wrc = 32'h0;
    logic [8:0]  last_tid = 9'h0;
    logic [63:0] last_data = 64'h0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk = n_chk + 1;
        if (act !== req) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Architectural view of the register file, addressed by 64-bit register byte-pair (DWORD address, LSB ignored).
    function automatic logic [63:0] m_reg(input logic [15:0] a);
        logic [15:0] base;
        base = a & 16'hFFFE;
        if (base == 16'h0000) return P_DFH;
        if (base == 16'h0002) return P_AFUL;
        if (base == 16'h0004) return P_AFUH;
        if (base == 16'h0010) return m_scr0;
        if (base == 16'h0012) return m_scr1;
        if (STATS && base == 16'h0014) return {32'h0, m_rdc};
        if (STATS && base == 16'h0016) return {32'h0, m_wrc};
        return 64'h0;
    endfunction

    function automatic logic [63:0] m_read(input logic [15:0] a, input logic [1:0] l);
        logic [63:0] v;
        v = m_reg(a);
        if (l != 2'd0) return v;
        return a[0] ? (v >> 32) : (v & 64'h0000_0000_FFFF_FFFF);
    endfunction

    function automatic logic [63:0] m_put(input logic [63:0] old, input logic [15:0] a,
                                          input logic [1:0] l, input logic [63:0] d);
        if (l != 2'd0) return d;
        if (a[0]) return {d[31:0], old[31:0]};
        return {old[63:32], d[31:0]};
    endfunction

    always @(posedge pClk) begin : model
        rsp_t r;
        logic [15:0] base;
        cyc = cyc + 1;
        if (rst_n === 1'b1) begin
            base = addr & 16'hFFFE;
            if (rd_valid) begin
                r.tid  = tid;
                r.data = m_read(addr, len);
                r.cyc  = cyc + 1;
                exp_q.push_back(r);
            end
            if (wr_valid) begin
                if (base == 16'h0010) m_scr0 = m_put(m_scr0, addr, len, wdata);
                if (base == 16'h0012) m_scr1 = m_put(m_scr1, addr, len, wdata);
                if (STATS && base == 16'h0014) m_rdc = 32'h0;
                else if (STATS && base == 16'h0016) m_wrc = 32'h0;
                else m_wrc = m_wrc + 32'h1;
            end
            if (rd_valid) m_rdc = m_rdc + 32'h1;
        end
    end

    always @(negedge rst_n) begin
        exp_q.delete();
        m_scr0 = 64'h0;
        m_scr1 = 64'h0;
        m_rdc = 32'h0;
        m_wrc = 32'h0;
        last_tid = 9'h0;
        last_data = 64'h0;
    end

    always @(negedge pClk) begin : compare
        rsp_t e;
        rsp_t o;
        bit ev;
        ev = 1'b0;
        if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            ev = 1'b1;
        end
        chk("rsp_valid", {63'h0, rsp_valid}, {63'h0, ev});
        if (ev) begin
            chk("rsp_tid", {55'h0, rsp_tid}, {55'h0, e.tid});
            chk("rsp_data", rsp_data, e.data);
            last_tid = e.tid;
            last_data = e.data;
        end else begin
            chk("held_tid", {55'h0, rsp_tid}, {55'h0, last_tid});
            chk("held_data", rsp_data, last_data);
        end
        if (rsp_valid === 1'b1) begin
            o.tid = rsp_tid;
            o.data = rsp_data;
            o.cyc = cyc;
            obs_q.push_back(o);
        end
    end

    task automatic drive(input logic rd, input logic wr, input logic [15:0] a, input logic [1:0] l,
                         input logic [8:0] t, input logic [63:0] d);
        @(negedge pClk);
        rd_valid = rd;
        wr_valid = wr;
        addr = a;
        len = l;
        tid = t;
        wdata = d;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge pClk);
            rd_valid = 1'b0;
            wr_valid = 1'b0;
        end
    endtask

    task automatic exp_obs(input string nm, input logic [8:0] t, input logic [63:0] d);
        rsp_t o;
        if (obs_q.size() == 0) begin
            n_chk = n_chk + 1;
            n_fail = n_fail + 1;
            $display("FAIL %s: got no response, expected tid %h data %h", nm, t, d);
        end else begin
            o = obs_q.pop_front();
            chk({nm, "_tid"}, {55'h0, o.tid}, {55'h0, t});
            chk({nm, "_data"}, o.data, d);
        end
    endtask

    initial begin : main
        int c0;
        rst_n = 1'b0;
        rd_valid = 1'b0;
        wr_valid = 1'b0;
        addr = 16'h0;
        len = 2'd0;
        tid = 9'h0;
        wdata = 64'h0;

        // Requests during reset must be ignored, outputs held at zero.
        drive(1'b1, 1'b1, 16'h0010, 2'd1, 9'h0AA, 64'hFFFF_FFFF_FFFF_FFFF);
        idle(1);
        chk("reset_valid", {63'h0, rsp_valid}, 64'h0);
        chk("reset_tid", {55'h0, rsp_tid}, 64'h0);
        chk("reset_data", rsp_data, 64'h0);

        // First cycle after release is a normal request cycle.
        obs_q.delete();
        drive(1'b1, 1'b0, 16'h0000, 2'd1, 9'h005, 64'h0);
        c0 = cyc;
        #2 rst_n = 1'b1;
        idle(4);
        chk("dfh_count", obs_q.size(), 1);
        if (obs_q.size() != 0) chk("dfh_latency", obs_q[0].cyc, c0 + 2);
        exp_obs("dfh", 9'h005, 64'h1000_0000_0000_1000);

        obs_q.delete();
        drive(1'b1, 1'b0, 16'h0010, 2'd1, 9'h011, 64'h0);
        drive(1'b0, 1'b1, 16'h0010, 2'd1, 9'h000, 64'hDEAD_BEEF_CAFE_F00D);
        drive(1'b1, 1'b0, 16'h0011, 2'd0, 9'h012, 64'h0);
        drive(1'b1, 1'b0, 16'h0010, 2'd0, 9'h013, 64'h0);
        drive(1'b0, 1'b1, 16'h0011, 2'd0, 9'h000, 64'hAAAA_AAAA_1234_5678);
        drive(1'b1, 1'b0, 16'h0010, 2'd1, 9'h014, 64'h0);
        drive(1'b0, 1'b1, 16'h0000, 2'd1, 9'h000, 64'hFFFF_FFFF_FFFF_FFFF);
        drive(1'b0, 1'b1, 16'h0100, 2'd1, 9'h000, 64'h5555_5555_5555_5555);
        drive(1'b1, 1'b0, 16'h0001, 2'd0, 9'h015, 64'h0);
        drive(1'b1, 1'b0, 16'h0000, 2'd3, 9'h016, 64'h0);
        idle(4);
        exp_obs("scr0_after_reset", 9'h011, 64'h0);
        exp_obs("scr0_hi_dw", 9'h012, 64'h0000_0000_DEAD_BEEF);
        exp_obs("scr0_lo_dw", 9'h013, 64'h0000_0000_CAFE_F00D);
        exp_obs("scr0_dw_write", 9'h014, 64'h1234_5678_CAFE_F00D);
        exp_obs("dfh_hi_dw", 9'h015, 64'h0000_0000_1000_0000);
        exp_obs("len3_as_8b", 9'h016, 64'h1000_0000_0000_1000);

        obs_q.delete();
        drive(1'b1, 1'b0, 16'h0002, 2'd1, 9'h001, 64'h0);
        c0 = cyc;
        drive(1'b1, 1'b0, 16'h0100, 2'd1, 9'h002, 64'h0);
        drive(1'b1, 1'b0, 16'h0012, 2'd1, 9'h003, 64'h0);
        idle(5);
        chk("b2b_count", obs_q.size(), 3);
        if (obs_q.size() == 3) begin
            chk("b2b_cyc0", obs_q[0].cyc, c0 + 2);
            chk("b2b_cyc2", obs_q[2].cyc, c0 + 4);
        end
        exp_obs("b2b_1", 9'h001, 64'h0123_4567_89AB_CDEF);
        exp_obs("b2b_2", 9'h002, 64'h0);
        exp_obs("b2b_3", 9'h003, 64'h0);

        obs_q.delete();
        drive(1'b1, 1'b1, 16'h0012, 2'd1, 9'h009, 64'h1);
        drive(1'b1, 1'b0, 16'h0012, 2'd1, 9'h00A, 64'h0);
        idle(4);
        exp_obs("rw_same_cycle", 9'h009, 64'h0);
        exp_obs("rw_after", 9'h00A, 64'h1);

        // Sweep of the map with interleaved writes; checked by the model only.
        for (int i = 0; i < 48; i++) begin
            logic [15:0] a;
            a = 16'(i % 24);
            drive(1'b1, (i % 3) == 0, a, 2'((i / 24) ^ (i & 1)), 9'(9'h040 + i),
                  {32'(i * 32'h0101_0101), 32'(~i)});
        end
        idle(4);

        // Reset in the cycle after a read is sampled drops that read.
        drive(1'b0, 1'b1, 16'h0010, 2'd1, 9'h000, 64'h1111_2222_3333_4444);
        drive(1'b1, 1'b0, 16'h0010, 2'd1, 9'h1AA, 64'h0);
        obs_q.delete();
        @(negedge pClk);
        rd_valid = 1'b0;
        wr_valid = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge pClk);
        #2 rst_n = 1'b1;
        idle(5);
        chk("inflight_dropped", obs_q.size(), 0);

        obs_q.delete();
        drive(1'b1, 1'b0, 16'h0010, 2'd1, 9'h021, 64'h0);
        drive(1'b1, 1'b0, 16'h0002, 2'd1, 9'h022, 64'h0);
        drive(1'b1, 1'b0, 16'h0004, 2'd1, 9'h023, 64'h0);
        drive(1'b1, 1'b0, 16'h0014, 2'd1, 9'h024, 64'h0);
        drive(1'b0, 1'b1, 16'h0014, 2'd1, 9'h000, 64'h0);
        drive(1'b0, 1'b1, 16'h0100, 2'd1, 9'h000, 64'h0);
        drive(1'b1, 1'b0, 16'h0014, 2'd1, 9'h025, 64'h0);
        drive(1'b1, 1'b0, 16'h0016, 2'd1, 9'h026, 64'h0);
        drive(1'b1, 1'b0, 16'h0014, 2'd0, 9'h027, 64'h0);
        idle(4);
        exp_obs("scr0_post_reset", 9'h021, 64'h0);
        exp_obs("afu_l", 9'h022, 64'h0123_4567_89AB_CDEF);
        exp_obs("afu_h", 9'h023, 64'hFEDC_BA98_7654_3210);
        exp_obs("rd_count_3", 9'h024, STATS ? 64'h3 : 64'h0);
        exp_obs("rd_count_clr", 9'h025, 64'h0);
        exp_obs("wr_count_1", 9'h026, STATS ? 64'h1 : 64'h0);
        exp_obs("rd_count_dw", 9'h027, STATS ? 64'h1 : 64'h0);

        chk("model_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ccip_mmio_responder.md
CCIP_MMIO_RESPONDER -- requirements
Module: ccip_mmio_responder

Interface
- REQ-001 SHALL have parameter DFH_VALUE, default 64'h1000_0000_0000_1000, meaning the value returned at the DFH register.
- REQ-002 SHALL have parameter AFU_ID_L, default 64'h0, meaning the low AFU ID word.
- REQ-003 SHALL have parameter AFU_ID_H, default 64'h0, meaning the high AFU ID word.
- REQ-004 SHALL have port pClk, input, 1 bit: the only clock; all logic is on its rising edge.
- REQ-005 SHALL have port pck_cp2af_softReset_n, input, 1 bit: asynchronous active-low reset.
- REQ-006 SHALL have port mmio_wr_valid, input, 1 bit: MMIO write request strobe (C0 MMIO write).
- REQ-007 SHALL have port mmio_rd_valid, input, 1 bit: MMIO read request strobe (C0 MMIO read).
- REQ-008 SHALL have port mmio_addr, input, 16 bits: DWORD address.
- REQ-009 SHALL have port mmio_len, input, 2 bits: 0 = 4B, 1 = 8B; other values are treated as 8B.
- REQ-010 SHALL have port mmio_tid, input, 9 bits: read transaction ID.
- REQ-011 SHALL have port mmio_wdata, input, 64 bits: write data.
- REQ-012 SHALL have port rsp_valid, output, 1 bit: C2 MMIO read response strobe.
- REQ-013 SHALL have port rsp_tid, output, 9 bits: echoed transaction ID.
- REQ-014 SHALL have port rsp_data, output, 64 bits: read data.

Function
- REQ-015 SHALL decode this register map (DWORD address): 0x0000 DFH RO; 0x0002 AFU_ID_L RO; 0x0004 AFU_ID_H RO; 0x0006 and 0x0008 RO zero; 0x0010 SCRATCH0 RW; 0x0012 SCRATCH1 RW.
- REQ-016 SHALL use a two-stage pipeline (capture/decode, then registered response), so a read sampled in cycle N produces rsp_valid=1 in cycle N+2.
- REQ-017 SHALL pulse rsp_valid for exactly one cycle per read, with rsp_tid equal to the captured mmio_tid.
- REQ-018 SHALL accept one read per cycle; back-to-back reads yield back-to-back responses, in order, with no drops.
- REQ-019 SHALL respond to every read, including unmapped addresses, which return 64'h0.
- REQ-020 SHALL serve an 8B access from the 64-bit register at mmio_addr with bit 0 cleared.
- REQ-021 SHALL serve a 4B read by returning the selected DWORD in rsp_data[31:0] and zero in [63:32]; addr[0]=1 selects the upper DWORD.
- REQ-022 SHALL, on a 4B write, update only the addressed DWORD of the RW register.
- REQ-023 SHALL ignore writes to RO or unmapped addresses without any side effect.
- REQ-024 SHALL apply a write in the cycle after it is sampled.
- REQ-025 SHALL return the pre-write value when a read and a write to the same register are sampled in the same cycle.
- REQ-026 SHALL hold rsp_data and rsp_tid stable whenever rsp_valid=0 (held at their last value, not re-decoded).

Reset
- REQ-027 SHALL, while pck_cp2af_softReset_n=0, immediately force rsp_valid=0, rsp_tid=0, rsp_data=0, SCRATCH0=0, SCRATCH1=0, all pipeline valids=0, and any counters=0.
- REQ-028 SHALL discard any in-flight read when reset asserts mid-operation; no response is emitted after release.
- REQ-029 SHALL ignore requests sampled during reset.
- REQ-030 SHALL treat the first cycle after reset release as a normal request cycle.

Configuration
- REQ-031 SHALL provide macro CCIP_MMIO_RESPONDER_STATS_EN.
- REQ-032 SHALL, when CCIP_MMIO_RESPONDER_STATS_EN is defined, map RD_COUNT at 0x0014 and WR_COUNT at 0x0016: 32-bit wrapping counters, zero-extended to 64 bits.
  - RD_COUNT increments on every sampled read; WR_COUNT increments on every sampled write, including to RO or unmapped addresses.
  - A read of a counter returns its value before that read's own increment.
  - Any write to a counter clears it to 0; that write is not itself counted.
- REQ-033 SHALL, when CCIP_MMIO_RESPONDER_STATS_EN is undefined, build no counter logic; 0x0014 and 0x0016 are unmapped and read 0.

Verification
- REQ-034 SHALL cover: after reset, 8B read addr 0x0000 tid 0x05 in cycle N -> rsp_valid in N+2, rsp_tid=0x05, rsp_data=DFH_VALUE.
- REQ-035 SHALL cover: 8B write 0x0010 = 64'hDEAD_BEEF_CAFE_F00D, then 4B read 0x0011 -> rsp_data=64'h0000_0000_DEAD_BEEF.
- REQ-036 SHALL cover: reads with tids 1,2,3 in consecutive cycles to 0x0002, 0x0100 and 0x0012 -> three consecutive responses, tids 1,2,3, data AFU_ID_L, 0, 0.
- REQ-037 SHALL cover: same-cycle write 0x0012 = 64'h1 and read 0x0012 -> response 0; a subsequent read -> 1.
- REQ-038 SHALL cover: read issued, reset asserted the next cycle -> no rsp_valid ever for that tid; SCRATCH0 reads 0 after release.
- REQ-039 SHALL cover, with STATS_EN: 3 reads then a read of 0x0014 -> returns 3; write 0x0014 then read -> returns 0.
